// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared opcodes, operand addresses and FSM state types for the command controller
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    // ST_ prefix keeps ST_ALU_FUN from colliding with the ALU_FUN port
    typedef enum logic [3:0] {
        ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT, ST_OP_A,
        ST_OP_B, ST_ALU_FUN, ST_ALU_WAIT, ST_TX_LO, ST_TX_HI, ST_TX_RESP
    } state_t;

    typedef enum logic [1:0] {TS_IDLE, TS_PEND, TS_HI, TS_LO} tx_state_t;

endpackage

// File: rtl/sys_tx_seq.sv
// sys_tx_seq: sends one byte to the UART TX and waits out its busy high->low cycle
module sys_tx_seq
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  done
);

    tx_state_t             state, state_n;
    logic [DATA_WIDTH-1:0] data_q, data_n, p_data_n;
    logic                  vld_n;

    // next state: stall while busy, issue, then wait for busy to rise and fall; a new start may chain onto done
    always_comb begin
        state_n  = state;
        data_n   = data_q;
        p_data_n = TX_P_DATA;
        vld_n    = 1'b0;
        done     = 1'b0;
        case (state)
            TS_PEND: if (!TX_BUSY) begin
                vld_n    = 1'b1;
                p_data_n = data_q;
                state_n  = TS_HI;
            end
            TS_HI: if (TX_BUSY) state_n = TS_LO;
            TS_LO: if (!TX_BUSY) begin
                done    = 1'b1;
                state_n = TS_IDLE;
            end
            default: ;
        endcase
        if (start && (state == TS_IDLE || done)) begin
            data_n   = data;
            vld_n    = !TX_BUSY;
            p_data_n = TX_BUSY ? TX_P_DATA : data;
            state_n  = TX_BUSY ? TS_PEND : TS_HI;
        end
    end

    // registered state and TX outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= TS_IDLE;
            data_q    <= '0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
        end else begin
            state     <= state_n;
            data_q    <= data_n;
            TX_P_DATA <= p_data_n;
            TX_D_VLD  <= vld_n;
        end
    end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: parses UART command frames and sequences register file, ALU and TX responses
module sys_cmd_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_Valid,
    input  logic                    TX_BUSY,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic [DATA_WIDTH-1:0]   WrData,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD
);

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_n, address_n;
    logic [2*DATA_WIDTH-1:0] res_q, res_n;
    logic [DATA_WIDTH-1:0]   wr_data_n, tx_data;
    logic [FUN_WIDTH-1:0]    alu_fun_n;
    logic                    wr_en_n, rd_en_n, alu_en_n, gate_n, tx_start, tx_done;
    logic                    is_alu_cmd;

    assign is_alu_cmd = RX_P_DATA == CMD_ALU_OP || RX_P_DATA == CMD_ALU_NOP;

    // next state and next registered outputs; strobes default low, data outputs hold
    always_comb begin
        state_n   = state;
        addr_n    = addr_q;
        res_n     = res_q;
        address_n = Address;
        wr_data_n = WrData;
        alu_fun_n = ALU_FUN;
        wr_en_n   = 1'b0;
        rd_en_n   = 1'b0;
        alu_en_n  = 1'b0;
        gate_n    = CLK_GATE_EN;
        tx_start  = 1'b0;
        tx_data   = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
        case (state)
            ST_IDLE: if (RX_D_VLD) begin
                state_n = RX_P_DATA == CMD_WR     ? ST_WR_ADDR :
                          RX_P_DATA == CMD_RD     ? ST_RD_ADDR :
                          RX_P_DATA == CMD_ALU_OP ? ST_OP_A    :
                          RX_P_DATA == CMD_ALU_NOP ? ST_ALU_FUN : ST_IDLE;
                gate_n  = is_alu_cmd;
            end
            ST_WR_ADDR: if (RX_D_VLD) begin
                addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
                state_n = ST_WR_DATA;
            end
            ST_WR_DATA: if (RX_D_VLD) begin
                wr_en_n   = 1'b1;
                address_n = addr_q;
                wr_data_n = RX_P_DATA;
                state_n   = ST_IDLE;
            end
            ST_RD_ADDR: if (RX_D_VLD) begin
                rd_en_n   = 1'b1;
                addr_n    = RX_P_DATA[ADDR_WIDTH-1:0];
                address_n = RX_P_DATA[ADDR_WIDTH-1:0];
                state_n   = ST_RD_WAIT;
            end
            ST_RD_WAIT: if (RdData_Valid) begin
                tx_start = 1'b1;
                tx_data  = RdData;
                state_n  = ST_TX_RESP;
            end
            ST_OP_A: if (RX_D_VLD) begin
                wr_en_n   = 1'b1;
                address_n = ADDR_WIDTH'(OPA_ADDR);
                wr_data_n = RX_P_DATA;
                state_n   = ST_OP_B;
            end
            ST_OP_B: if (RX_D_VLD) begin
                wr_en_n   = 1'b1;
                address_n = ADDR_WIDTH'(OPB_ADDR);
                wr_data_n = RX_P_DATA;
                state_n   = ST_ALU_FUN;
            end
            ST_ALU_FUN: if (RX_D_VLD) begin
                alu_en_n  = 1'b1;
                alu_fun_n = RX_P_DATA[FUN_WIDTH-1:0];
                state_n   = ST_ALU_WAIT;
            end
            ST_ALU_WAIT: if (OUT_Valid) begin
                res_n    = ALU_OUT;
                gate_n   = 1'b0;
                tx_start = 1'b1;
                tx_data  = ALU_OUT[DATA_WIDTH-1:0];
                state_n  = ST_TX_LO;
            end
            ST_TX_LO: if (tx_done) begin
                tx_start = 1'b1;
                state_n  = ST_TX_HI;
            end
            ST_TX_HI, ST_TX_RESP: if (tx_done) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // state, latched address/result and registered register-file/ALU outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            res_q       <= '0;
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            Address     <= '0;
            WrData      <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
        end else begin
            state       <= state_n;
            addr_q      <= addr_n;
            res_q       <= res_n;
            WrEn        <= wr_en_n;
            RdEn        <= rd_en_n;
            Address     <= address_n;
            WrData      <= wr_data_n;
            ALU_EN      <= alu_en_n;
            ALU_FUN     <= alu_fun_n;
            CLK_GATE_EN <= gate_n;
        end
    end

    sys_tx_seq #(.DATA_WIDTH(DATA_WIDTH)) u_tx_seq (
        .CLK       (CLK),
        .RST       (RST),
        .start     (tx_start),
        .data      (tx_data),
        .TX_BUSY   (TX_BUSY),
        .TX_P_DATA (TX_P_DATA),
        .TX_D_VLD  (TX_D_VLD),
        .done      (tx_done)
    );

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// tb_sys_cmd_ctrl: directed and randomized frame checks against a frame-level model of the controller
module tb_sys_cmd_ctrl;

    localparam int K_WR = 0, K_RD = 1, K_ALU = 2, K_TX = 3;

    typedef struct {int k; int a; int b; int t;} ev_t;

    logic        CLK, RST;
    logic [7:0]  RX_P_DATA, RdData, TX_P_DATA, WrData;
    logic        RX_D_VLD, rd_vld, alu_vld, spur, uart_busy, tx_hold, busy;
    logic [15:0] alu_out;
    logic        WrEn, RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD;
    logic [3:0]  Address, ALU_FUN;

    logic [7:0]  regs [16];
    logic [7:0]  m_regs [16];
    ev_t         obs_q[$];
    ev_t         exp_q[$];
    int          cyc = 0;
    int          viol = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        p_wr = 0, p_rd = 0, p_alu = 0, p_tx = 0;

    assign busy = uart_busy | tx_hold;

    sys_cmd_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .RdData       (RdData),
        .RdData_Valid (rd_vld | spur),
        .ALU_OUT      (alu_out),
        .OUT_Valid    (alu_vld | spur),
        .TX_BUSY      (busy),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .ALU_EN       (ALU_EN),
        .ALU_FUN      (ALU_FUN),
        .CLK_GATE_EN  (CLK_GATE_EN),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        logic [15:0] x = {8'h00, a};
        logic [15:0] y = {8'h00, b};
        case (f)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x * y;
            4'd3: return x & y;
            4'd4: return x | y;
            4'd5: return x ^ y;
            default: return {a, b};
        endcase
    endfunction

    function automatic int n_kind(input int k, input int base);
        int n = 0;
        for (int i = base; i < obs_q.size(); i++) if (obs_q[i].k == k) n++;
        return n;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // environment register file, event log and protocol watch
    always @(negedge CLK) begin
        if (WrEn) begin
            obs_q.push_back('{K_WR, int'(Address), int'(WrData), cyc});
            regs[Address] <= WrData;
        end
        if (RdEn) obs_q.push_back('{K_RD, int'(Address), 0, cyc});
        if (ALU_EN) obs_q.push_back('{K_ALU, int'(ALU_FUN), 0, cyc});
        if (TX_D_VLD) obs_q.push_back('{K_TX, int'(TX_P_DATA), 0, cyc});
        if ((TX_D_VLD && busy) || (WrEn && p_wr) || (RdEn && p_rd) || (ALU_EN && p_alu) || (TX_D_VLD && p_tx))
            viol <= viol + 1;
        p_wr  <= WrEn;
        p_rd  <= RdEn;
        p_alu <= ALU_EN;
        p_tx  <= TX_D_VLD;
    end

    // register file read responder: data two cycles after RdEn
    initial begin
        logic [3:0] a;
        rd_vld = 0;
        RdData = 0;
        forever begin
            @(negedge CLK);
            if (RdEn) begin
                a = Address;
                @(posedge CLK); #1;
                @(posedge CLK); #1;
                RdData = regs[a];
                rd_vld = 1;
                @(posedge CLK); #1;
                rd_vld = 0;
            end
        end
    end

    // ALU responder: result from operand registers two cycles after ALU_EN
    initial begin
        logic [3:0] f;
        alu_vld = 0;
        alu_out = 0;
        forever begin
            @(negedge CLK);
            if (ALU_EN) begin
                f = ALU_FUN;
                @(posedge CLK); #1;
                @(posedge CLK); #1;
                alu_out = alu_f(regs[0], regs[1], f);
                alu_vld = 1;
                @(posedge CLK); #1;
                alu_vld = 0;
            end
        end
    end

    // UART TX responder: busy for 1..4 cycles after each accepted byte
    initial begin
        int n;
        uart_busy = 0;
        forever begin
            @(negedge CLK);
            if (TX_D_VLD) begin
                n = $urandom_range(1, 4);
                @(posedge CLK); #1;
                uart_busy = 1;
                repeat (n) @(posedge CLK);
                #1;
                uart_busy = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK); #1;
        RX_P_DATA = b;
        RX_D_VLD  = 1;
        @(posedge CLK); #1;
        RX_D_VLD  = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1;
        step(3);
        n_checks++;
        if ({WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD});
        end
        RST = 0;
        step(2);
        n_checks++;
        if ({WrEn, RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got strobes %b required 00000", {WrEn, RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD});
        end
    endtask

    task automatic test_write();
        int base = obs_q.size();
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h3C);
        n_checks++;
        if ({WrEn, Address, WrData} !== {1'b1, 4'h5, 8'h3C}) begin
            n_fail++;
            $display("FAIL write_strobe: got WrEn=%b Address=%h WrData=%h required 1/5/3c", WrEn, Address, WrData);
        end
        step(1);
        n_checks++;
        if ({WrEn, Address, WrData} !== {1'b0, 4'h5, 8'h3C}) begin
            n_fail++;
            $display("FAIL write_hold: got WrEn=%b Address=%h WrData=%h required 0/5/3c", WrEn, Address, WrData);
        end
        spur = 1;
        step(1);
        spur = 0;
        step(10);
        n_checks++;
        if (n_kind(K_TX, base) !== 0 || n_kind(K_WR, base) !== 1) begin
            n_fail++;
            $display("FAIL stray_valid_in_idle: got tx=%0d wr=%0d required tx=0 wr=1", n_kind(K_TX, base), n_kind(K_WR, base));
        end
    endtask

    task automatic test_read();
        int base = obs_q.size();
        send_byte(8'hBB);
        send_byte(8'h05);
        n_checks++;
        if ({RdEn, Address} !== {1'b1, 4'h5}) begin
            n_fail++;
            $display("FAIL read_strobe: got RdEn=%b Address=%h required 1/5", RdEn, Address);
        end
        step(2);
        n_checks++;
        if (TX_D_VLD !== 1'b0) begin
            n_fail++;
            $display("FAIL read_tx_early: got TX_D_VLD=%b required 0", TX_D_VLD);
        end
        step(1);
        n_checks++;
        if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'h3C}) begin
            n_fail++;
            $display("FAIL read_tx: got TX_D_VLD=%b TX_P_DATA=%h required 1/3c", TX_D_VLD, TX_P_DATA);
        end
        step(12);
        n_checks++;
        if (n_kind(K_TX, base) !== 1 || n_kind(K_RD, base) !== 1) begin
            n_fail++;
            $display("FAIL read_single: got tx=%0d rd=%0d required 1/1", n_kind(K_TX, base), n_kind(K_RD, base));
        end
    endtask

    task automatic test_alu();
        int base = obs_q.size();
        ev_t tx[$];
        send_byte(8'hCC);
        n_checks++;
        if (CLK_GATE_EN !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_gate_entry: got %b required 1", CLK_GATE_EN);
        end
        send_byte(8'h0A);
        n_checks++;
        if ({WrEn, Address, WrData} !== {1'b1, 4'h0, 8'h0A}) begin
            n_fail++;
            $display("FAIL alu_opa: got WrEn=%b Address=%h WrData=%h required 1/0/0a", WrEn, Address, WrData);
        end
        send_byte(8'h03);
        n_checks++;
        if ({WrEn, Address, WrData} !== {1'b1, 4'h1, 8'h03}) begin
            n_fail++;
            $display("FAIL alu_opb: got WrEn=%b Address=%h WrData=%h required 1/1/03", WrEn, Address, WrData);
        end
        send_byte(8'h00);
        n_checks++;
        if ({ALU_EN, ALU_FUN, CLK_GATE_EN} !== {1'b1, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL alu_en: got ALU_EN=%b ALU_FUN=%h gate=%b required 1/0/1", ALU_EN, ALU_FUN, CLK_GATE_EN);
        end
        for (int i = 0; i < 60 && n_kind(K_TX, base) < 2; i++) @(posedge CLK);
        step(8);
        foreach (obs_q[i]) if (i >= base && obs_q[i].k == K_TX) tx.push_back(obs_q[i]);
        n_checks++;
        if (tx.size() !== 2) begin
            n_fail++;
            $display("FAIL alu_tx_count: got %0d required 2", tx.size());
        end else begin
            n_checks++;
            if (tx[0].a !== 'h0D || tx[1].a !== 'h00 || tx[1].t - tx[0].t < 3) begin
                n_fail++;
                $display("FAIL alu_tx_bytes: got %h,%h gap %0d required 0d,00 gap>=3", tx[0].a, tx[1].a, tx[1].t - tx[0].t);
            end
        end
    endtask

    task automatic test_alu_nop();
        int base = obs_q.size();
        send_byte(8'h55);
        step(3);
        n_checks++;
        if (obs_q.size() !== base || CLK_GATE_EN !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_55: got events=%0d gate=%b required 0/0", obs_q.size() - base, CLK_GATE_EN);
        end
        send_byte(8'hDD);
        send_byte(8'h02);
        n_checks++;
        if ({ALU_EN, ALU_FUN, CLK_GATE_EN} !== {1'b1, 4'h2, 1'b1}) begin
            n_fail++;
            $display("FAIL nop_alu_en: got ALU_EN=%b ALU_FUN=%h gate=%b required 1/2/1", ALU_EN, ALU_FUN, CLK_GATE_EN);
        end
        step(2);
        n_checks++;
        if (CLK_GATE_EN !== 1'b1) begin
            n_fail++;
            $display("FAIL nop_gate_hold: got %b required 1", CLK_GATE_EN);
        end
        step(1);
        n_checks++;
        if ({CLK_GATE_EN, TX_D_VLD, TX_P_DATA} !== {1'b0, 1'b1, 8'h1E}) begin
            n_fail++;
            $display("FAIL nop_result: got gate=%b TX_D_VLD=%b TX_P_DATA=%h required 0/1/1e", CLK_GATE_EN, TX_D_VLD, TX_P_DATA);
        end
        step(15);
    endtask

    task automatic test_busy_stall();
        int base;
        logic early = 0;
        send_byte(8'hAA);
        send_byte(8'h07);
        send_byte(8'h11);
        step(2);
        base = obs_q.size();
        tx_hold = 1;
        send_byte(8'hBB);
        send_byte(8'h07);
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (TX_D_VLD !== 1'b0) early = 1;
        end
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL busy_stall: got TX_D_VLD=1 while busy required 0");
        end
        tx_hold = 0;
        step(1);
        n_checks++;
        if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'h11}) begin
            n_fail++;
            $display("FAIL busy_release: got TX_D_VLD=%b TX_P_DATA=%h required 1/11", TX_D_VLD, TX_P_DATA);
        end
        step(12);
        n_checks++;
        if (n_kind(K_TX, base) !== 1) begin
            n_fail++;
            $display("FAIL busy_single: got %0d tx required 1", n_kind(K_TX, base));
        end
    endtask

    task automatic test_reset_midframe();
        int base = obs_q.size();
        send_byte(8'hAA);
        send_byte(8'h05);
        #2;
        RST = 1;
        #1;
        n_checks++;
        if ({WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD} !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset_outputs: got %h required 0", {WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD});
        end
        step(1);
        RST = 0;
        send_byte(8'h3C);
        step(4);
        n_checks++;
        if (obs_q.size() !== base) begin
            n_fail++;
            $display("FAIL midframe_discard: got %0d events required 0", obs_q.size() - base);
        end
        send_byte(8'hAA);
        send_byte(8'h09);
        send_byte(8'h22);
        n_checks++;
        if ({WrEn, Address, WrData} !== {1'b1, 4'h9, 8'h22}) begin
            n_fail++;
            $display("FAIL midframe_fresh_write: got WrEn=%b Address=%h WrData=%h required 1/9/22", WrEn, Address, WrData);
        end
        step(2);
    endtask

    task automatic test_random();
        int base, kind;
        logic [7:0] b[$];
        logic [7:0] x, y, f, j;
        logic [15:0] r;
        for (int fr = 0; fr < 56; fr++) begin
            base = obs_q.size();
            exp_q.delete();
            b.delete();
            kind = fr < 16 ? 0 : $urandom_range(0, 4);
            x = fr < 16 ? 8'(fr + 16 * $urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            f = 8'($urandom_range(0, 255));
            case (kind)
                0: begin
                    b.push_back(8'hAA); b.push_back(x); b.push_back(y);
                    exp_q.push_back('{K_WR, int'(x[3:0]), int'(y), 0});
                    m_regs[x[3:0]] = y;
                end
                1: begin
                    b.push_back(8'hBB); b.push_back(x);
                    exp_q.push_back('{K_RD, int'(x[3:0]), 0, 0});
                    exp_q.push_back('{K_TX, int'(m_regs[x[3:0]]), 0, 0});
                end
                2, 3: begin
                    if (kind == 2) begin
                        b.push_back(8'hCC); b.push_back(x); b.push_back(y);
                        exp_q.push_back('{K_WR, 0, int'(x), 0});
                        exp_q.push_back('{K_WR, 1, int'(y), 0});
                        m_regs[0] = x;
                        m_regs[1] = y;
                    end else b.push_back(8'hDD);
                    b.push_back(f);
                    r = alu_f(m_regs[0], m_regs[1], f[3:0]);
                    exp_q.push_back('{K_ALU, int'(f[3:0]), 0, 0});
                    exp_q.push_back('{K_TX, int'(r[7:0]), 0, 0});
                    exp_q.push_back('{K_TX, int'(r[15:8]), 0, 0});
                end
                default: begin
                    do j = 8'($urandom_range(0, 255)); while (j inside {8'hAA, 8'hBB, 8'hCC, 8'hDD});
                    b.push_back(j);
                end
            endcase
            foreach (b[i]) begin
                repeat ($urandom_range(0, 2)) @(posedge CLK);
                send_byte(b[i]);
            end
            if (kind inside {[1:3]} && $urandom_range(0, 1) == 1) send_byte(8'($urandom_range(0, 255)));
            for (int i = 0; i < 100 && obs_q.size() - base < exp_q.size(); i++) @(posedge CLK);
            step(10);
            n_checks++;
            if (obs_q.size() - base !== exp_q.size()) begin
                n_fail++;
                $display("FAIL rand_count frame %0d kind %0d: got %0d events required %0d", fr, kind, obs_q.size() - base, exp_q.size());
            end else foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[base+i].k !== exp_q[i].k || obs_q[base+i].a !== exp_q[i].a || obs_q[base+i].b !== exp_q[i].b) begin
                    n_fail++;
                    $display("FAIL rand_ev[%0d] frame %0d: got k=%0d a=%0h b=%0h required k=%0d a=%0h b=%0h",
                             i, fr, obs_q[base+i].k, obs_q[base+i].a, obs_q[base+i].b, exp_q[i].k, exp_q[i].a, exp_q[i].b);
                end
            end
        end
    endtask

    task automatic test_protocol();
        n_checks++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL strobe_protocol: got %0d violations required 0", viol);
        end
    endtask

    initial begin
        RST = 1;
        RX_D_VLD = 0;
        RX_P_DATA = 0;
        spur = 0;
        tx_hold = 0;
        test_reset();
        test_write();
        test_read();
        test_alu();
        test_alu_nop();
        test_busy_stall();
        test_reset_midframe();
        test_random();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_cmd_ctrl.md
# sys_cmd_ctrl

Command-level system controller for the UART receive path. It consumes the byte stream produced by the UART RX (parallel data plus a one-cycle valid pulse) and parses framed commands. It then sequences the register file and the ALU, and schedules response bytes into the UART TX. It sits between the UART RX/TX pair and the register file/ALU in the final system, in the reference clock domain.

## Interface
- DATA_WIDTH, 8, UART byte width and register-file word width
- ADDR_WIDTH, 4, register-file address width
- FUN_WIDTH, 4, ALU function-code width
- CLK  in  1  system clock
- RST  in  1  reset; one clock domain, reset asynchronous and active-high
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
- RdData  in  DATA_WIDTH  register-file read data
- RdData_Valid  in  1  read data valid pulse
- ALU_OUT  in  2*DATA_WIDTH  ALU result
- OUT_Valid  in  1  ALU result valid pulse
- TX_BUSY  in  1  UART TX busy
- WrEn, RdEn  out  1  register-file write/read strobes, one cycle each
- Address  out  ADDR_WIDTH  register-file address
- WrData  out  DATA_WIDTH  register-file write data
- ALU_EN  out  1  one-cycle ALU start
- ALU_FUN  out  FUN_WIDTH  ALU function
- CLK_GATE_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  DATA_WIDTH  byte to transmit
- TX_D_VLD  out  1  one-cycle transmit request

## Operation
- Commands are carried in the first byte; bytes arrive only on RX_D_VLD.
  - 0xAA write: addr, data.
  - 0xBB read: addr.
  - 0xCC ALU with operands: A, B, fun.
  - 0xDD ALU without operands: fun.
- Addresses use the low ADDR_WIDTH bits of the byte; the function code uses the low FUN_WIDTH bits.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI, TX_RESP.
- IDLE transitions: 0xAA goes to WR_ADDR, 0xBB to RD_ADDR, 0xCC to OP_A, 0xDD to ALU_FUN. Any other byte is ignored and the block stays in IDLE.
- Write path: WR_ADDR latches the address and moves to WR_DATA. WR_DATA pulses WrEn with Address/WrData, then returns to IDLE.
- Read path: RD_ADDR pulses RdEn with Address and moves to RD_WAIT. On RdData_Valid the block latches RdData and moves to TX_RESP, which sends one byte and returns to IDLE.
- OP_A writes the byte to address 0. OP_B writes the byte to address 1 (WrEn pulse). Both then advance.
- ALU_FUN pulses ALU_EN with ALU_FUN and moves to ALU_WAIT. On OUT_Valid the block latches ALU_OUT, then sends the low byte (TX_LO) followed by the high byte (TX_HI).
- CLK_GATE_EN is high from entry into OP_A/ALU_FUN until OUT_Valid is captured.
- RX_D_VLD pulses received in any wait or TX state are dropped. No queueing.
- Byte send handshake:
  - Issue TX_D_VLD only while TX_BUSY=0.
  - Then wait for TX_BUSY=1, then for TX_BUSY=0, before the next byte or the return to IDLE.

## Timing
- Reset: all outputs 0, state IDLE, latched address/result 0.
- All outputs are registered. Each strobe appears in the cycle after the RX_D_VLD or valid pulse that caused it, with qualifying data stable in the same cycle.
- Write latency: final byte RX_D_VLD at cycle n gives WrEn=1 at n+1.
- Read latency: RdEn at n+1; TX_D_VLD issued the cycle after RdData_Valid if TX_BUSY=0.
- ALU latency: ALU_EN at n+1.
- Strobes (WrEn, RdEn, ALU_EN, TX_D_VLD) are never asserted for more than one consecutive cycle.
- Address, WrData, ALU_FUN and TX_P_DATA hold their last value between strobes.
- RdData_Valid or OUT_Valid arriving outside RD_WAIT/ALU_WAIT is ignored.
- Reset mid-frame: immediate return to IDLE with all strobes deasserted. A partial frame is discarded and never resumed.
- A TX_BUSY=1 already present when a send is due stalls the send until TX_BUSY=0.

## Structure
- Shared package sys_ctrl_pkg holds:
  - command opcodes (CMD_WR=0xAA, CMD_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD),
  - state enumeration,
  - operand addresses (OPA_ADDR=0, OPB_ADDR=1).
- One sub-module, sys_tx_seq, performs the single-byte TX send/busy handshake and reports done. The main FSM uses it for TX_RESP, TX_LO and TX_HI.

## Test plan
- Write frame 0xAA,0x05,0x3C → single WrEn pulse with Address=5, WrData=0x3C; then IDLE.
- Read frame 0xBB,0x05; RdData=0x3C valid 2 cycles after RdEn → one TX_D_VLD with TX_P_DATA=0x3C.
- ALU frame 0xCC,0x0A,0x03,0x00:
  - writes 0x0A to address 0 and 0x03 to address 1;
  - ALU_EN with ALU_FUN=0;
  - ALU_OUT=0x000D → TX bytes 0x0D then 0x00, each gated on a TX_BUSY high→low cycle.
- Byte 0x55 in IDLE, then 0xDD,0x02 → 0x55 ignored; ALU_EN with ALU_FUN=2; CLK_GATE_EN high until OUT_Valid.
- RST asserted after 0xAA,0x05 → all outputs 0. Next 0x3C is ignored (no WrEn) and the FSM stays in IDLE.
- TX_BUSY held 1 when the read response is due → TX_D_VLD stays 0 until TX_BUSY falls, then pulses once.
